// File: rtl/param_frame_tx.sv
// param_frame_tx: latches the pulse-parameter set, converts each field to ASCII decimal and sends the 30-byte
// "a" command frame as UART 8N1. Define PARAM_FRAME_CHECKSUM_EN to replace the CR terminator with an XOR checksum.
module param_frame_tx #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115_200,
  parameter logic [7:0]  CMD_CHAR  = 8'h61
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] pulses_cycle,
  input  logic [9:0]  pulses_number,
  input  logic        status_ecg,
  input  logic [15:0] pulse_voltage,
  input  logic [15:0] pulse_width,
  input  logic [15:0] pulse_frequency,
  input  logic [7:0]  pulse_interval,
  input  logic [15:0] pulse_number,
  output logic        busy,
  output logic        done,
  output logic        uart_tx
);

  localparam int unsigned BIT_CYC = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W   = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_LAST_M1 = CNT_W'(BIT_CYC - 2);
  localparam int NF = 8;

  typedef enum logic [2:0] {IDLE, CONV, LOAD, START_BIT, DATA, STOP, FIN} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [4:0]       byte_idx, byte_idx_next;
  logic [7:0]       cur_byte, cur_byte_next;
  logic             tx_next;
  logic             accept;

  // Per field: remainder being converted and the thousands/hundreds/tens digits; the ones digit is the final remainder.
  logic [13:0]   rem [NF];
  logic [3:0]    dig [NF][3];
  logic [1:0]    stage;
  logic [13:0]   weight;
  logic [NF-1:0] can_sub;
  logic          conv_last;
  logic [7:0]    frame [30];
  logic [7:0]    term_byte;

  function automatic logic [13:0] clamp(input logic [15:0] v, input logic [13:0] lim);
    return (v > {2'b00, lim}) ? lim : v[13:0];
  endfunction

  function automatic logic [7:0] asc(input logic [3:0] d);
    return {4'h3, d};
  endfunction

  assign accept = start && ((state == IDLE) || (state == FIN));

  always_comb begin
    weight  = 14'd10;
    can_sub = '0;
    unique case (stage)
      2'd0:    weight = 14'd1000;
      2'd1:    weight = 14'd100;
      default: weight = 14'd10;
    endcase
    for (int f = 0; f < NF; f++) can_sub[f] = (rem[f] >= weight);
    conv_last = (stage == 2'd2) && (can_sub == '0);
  end

  // All fields convert in parallel; a stage advances once no field can subtract its weight any more.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      stage <= 2'd0;
    end else if (accept) begin
      rem[0] <= clamp({2'b00, pulses_cycle}, 14'd9999);
      rem[1] <= clamp({6'b0, pulses_number}, 14'd999);
      rem[2] <= clamp({15'b0, status_ecg}, 14'd9);
      rem[3] <= clamp(pulse_voltage, 14'd9999);
      rem[4] <= clamp(pulse_width, 14'd9999);
      rem[5] <= clamp(pulse_frequency, 14'd9999);
      rem[6] <= clamp({8'b0, pulse_interval}, 14'd99);
      rem[7] <= clamp(pulse_number, 14'd999);
      for (int f = 0; f < NF; f++)
        for (int d = 0; d < 3; d++) dig[f][d] <= 4'd0;
      stage <= 2'd0;
    end else if (state == CONV) begin
      for (int f = 0; f < NF; f++) begin
        if (can_sub[f]) begin
          rem[f]        <= rem[f] - weight;
          dig[f][stage] <= dig[f][stage] + 4'd1;
        end
      end
      if ((can_sub == '0) && (stage != 2'd2)) stage <= stage + 2'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < 30; i++) frame[i] = 8'h30;
    frame[26] = asc(dig[0][0]); frame[25] = asc(dig[0][1]);
    frame[24] = asc(dig[0][2]); frame[23] = asc(rem[0][3:0]);
    frame[22] = asc(dig[1][1]); frame[21] = asc(dig[1][2]); frame[20] = asc(rem[1][3:0]);
    frame[19] = asc(rem[2][3:0]);
    frame[18] = asc(dig[3][0]); frame[17] = asc(dig[3][1]);
    frame[16] = asc(dig[3][2]); frame[15] = asc(rem[3][3:0]);
    frame[14] = asc(dig[4][0]); frame[13] = asc(dig[4][1]);
    frame[12] = asc(dig[4][2]); frame[11] = asc(rem[4][3:0]);
    frame[10] = asc(dig[5][0]); frame[9]  = asc(dig[5][1]);
    frame[8]  = asc(dig[5][2]); frame[7]  = asc(rem[5][3:0]);
    frame[6]  = asc(dig[6][2]); frame[5]  = asc(rem[6][3:0]);
    frame[4]  = asc(dig[7][1]); frame[3]  = asc(dig[7][2]); frame[2] = asc(rem[7][3:0]);
    frame[1]  = CMD_CHAR;
    frame[0]  = term_byte;
  end

`ifdef PARAM_FRAME_CHECKSUM_EN
  logic [7:0] csum_q, csum_next;

  always_comb begin
    csum_next = 8'h00;
    for (int i = 1; i < 30; i++) csum_next = csum_next ^ frame[i];
  end

  always_ff @(posedge sys_clk) begin
    if (rst) csum_q <= 8'h00;
    else if ((state == CONV) && conv_last) csum_q <= csum_next;
  end

  assign term_byte = csum_q;
`else
  assign term_byte = 8'h0D;
`endif

  // A non-final STOP is one cycle short because LOAD supplies the last high cycle of that stop bit.
  always_comb begin
    state_next    = state;
    bit_cnt_next  = bit_cnt;
    bit_idx_next  = bit_idx;
    byte_idx_next = byte_idx;
    cur_byte_next = cur_byte;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next    = CONV;
          byte_idx_next = 5'd29;
        end
      end
      CONV: if (conv_last) state_next = LOAD;
      LOAD: begin
        cur_byte_next = frame[byte_idx];
        bit_cnt_next  = '0;
        bit_idx_next  = 3'd0;
        state_next    = START_BIT;
      end
      START_BIT: begin
        if (bit_cnt == CNT_LAST) begin
          bit_cnt_next = '0;
          state_next   = DATA;
        end else bit_cnt_next = bit_cnt + 1'b1;
      end
      DATA: begin
        if (bit_cnt == CNT_LAST) begin
          bit_cnt_next = '0;
          if (bit_idx == 3'd7) state_next = STOP;
          else bit_idx_next = bit_idx + 3'd1;
        end else bit_cnt_next = bit_cnt + 1'b1;
      end
      STOP: begin
        if (byte_idx == 5'd0) begin
          if (bit_cnt == CNT_LAST) state_next = FIN;
          else bit_cnt_next = bit_cnt + 1'b1;
        end else if (bit_cnt == CNT_LAST_M1) begin
          state_next    = LOAD;
          byte_idx_next = byte_idx - 5'd1;
        end else bit_cnt_next = bit_cnt + 1'b1;
      end
      FIN: begin
        if (start) begin
          state_next    = CONV;
          byte_idx_next = 5'd29;
        end else state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    tx_next = 1'b1;
    if (state_next == START_BIT) tx_next = 1'b0;
    else if (state_next == DATA) tx_next = cur_byte_next[bit_idx_next];
  end

  // Outputs are registered from the next state so the serial line never glitches.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 5'd0;
      cur_byte <= 8'hFF;
      uart_tx  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      bit_cnt  <= bit_cnt_next;
      bit_idx  <= bit_idx_next;
      byte_idx <= byte_idx_next;
      cur_byte <= cur_byte_next;
      uart_tx  <= tx_next;
      busy     <= (state_next != IDLE) && (state_next != FIN);
      done     <= (state_next == FIN);
    end
  end

endmodule
